shift_issue: RTL and testbench
==============================

# shift_issue

Registered issue stage directly upstream of the integer shifter. Decodes shift and rotate instruction fields into the shifter's control inputs (Right, Rotate, W64, SubArith), extracts the shift amount, and flags illegal encodings. Holds operands in a 2-entry skid buffer with valid/ready handshakes on both sides. Its outputs drive the shifter's A, Amt and control inputs unchanged.

## Interface
Parameters:
- XLEN, 64 (from config_pkg): datapath width; 32 or 64.
- LOG_XLEN, $clog2(XLEN): shift-amount width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- InValid  in  1  upstream offers an operation.
- InReady  out  1  stage can accept; transfer when InValid & InReady.
- Funct3  in  3  instruction funct3.
- Funct7  in  7  instruction bits [31:25]. For RV64 immediates, bit 0 is shamt[5].
- OpImm  in  1  immediate form (OP-IMM / OP-IMM-32).
- W64In  in  1  word form (OP-32 / OP-IMM-32).
- SrcA  in  XLEN  shift source.
- SrcB  in  XLEN  rs2 or sign-extended immediate; amount = SrcB[LOG_XLEN-1:0].
- Flush  in  1  discard all held and offered entries.
- OutValid  out  1  entry is presented to the shifter/writeback.
- OutReady  in  1  downstream consumes; transfer when OutValid & OutReady.
- A  out  XLEN  registered SrcA.
- Amt  out  LOG_XLEN  registered SrcB[LOG_XLEN-1:0].
- Right, Rotate, W64, SubArith  out  1 each  decoded shifter controls.
- Illegal  out  1  entry is an illegal encoding. Valid only with OutValid.

## Operation
- Decode. F = Funct7 for RV32 or register forms; F = {Funct7[6:1], 0} for RV64 immediates.
  - Funct3=001, F=0000000: SLL. All controls 0.
  - Funct3=101, F=0000000: SRL. Right=1.
  - Funct3=101, F=0100000: SRA. Right=1, SubArith=1.
  - Funct3=001, F=0110000, !OpImm: ROL. Rotate=1.
  - Funct3=101, F=0110000: ROR / RORI. Right=1, Rotate=1.
  - W64 = W64In on all legal forms.
- Illegal conditions. Any one of these sets Illegal=1 and forces Right, Rotate, W64 and SubArith to 0:
  - any other Funct3 or F value;
  - ROL with OpImm;
  - W64In with XLEN=32;
  - W64In & OpImm & Funct7[0]=1;
  - RV32 immediate with Funct7[0]=1.
- Illegal entries still flow through the handshake. A and Amt carry the inputs unmodified.
- Amt is not truncated for W64. The shifter masks it.
- Skid buffer: an output register (OV) and a skid register (SV).
  - InReady = !SV.
  - The output register loads from skid (if SV) or from the input when OV=0 or OutReady.
  - If the input is accepted while OV=1 and !OutReady, the entry goes to skid.
  - Order is strictly FIFO.
- Flush: OV and SV clear at the next edge. An InValid in the same cycle is not accepted, regardless of InReady. Data registers are left unchanged.

## Timing
- Reset values: OutValid=0, InReady=1, Illegal=0, A=0, Amt=0, all controls 0, skid empty.
- Reset asserted mid-operation drops both entries immediately (asynchronous).
- Latency: input accepted at edge N → OutValid=1 with decoded fields after edge N.
- Throughput: 1 op/cycle while OutReady=1.
- Backpressure:
  - OutReady low with OV=1: outputs are held stable.
  - One more entry is absorbed into skid.
  - InReady drops the cycle after the skid fills.
- Simultaneous events:
  - Skid full with OutReady=1: the skid entry moves to output.
  - A new input is not accepted that cycle, since InReady=0.
- InReady and all outputs are register-driven. There is no combinational InValid→OutValid or OutReady→InReady path.

## Configuration
- SHIFT_ROTATE_EN defined: ROL, ROR and RORI (incl. W forms) decode as above.
- SHIFT_ROTATE_EN undefined:
  - F=0110000 is illegal.
  - Rotate is tied to 0.
  - All other behaviour is identical.

## Test plan
- XLEN=64, SRAI: Funct3=101, Funct7=0100001, OpImm=1, SrcB=0x21 → next cycle OutValid=1, Right=1, SubArith=1, Amt=33, Illegal=0.
- SRAIW with Funct7[0]=1 (W64In=1, OpImm=1) → Illegal=1, all controls 0, OutValid=1.
- Back-to-back ops 1, 2, 3 with OutReady low for 3 cycles:
  - op1 is held on the outputs;
  - op2 goes to skid;
  - InReady=0;
  - after release, outputs are 1, 2, 3 in consecutive cycles with no loss.
- Flush with both entries full and InValid=1 → next cycle OutValid=0, InReady=1; the offered op does not appear later.
- ROL register form, Funct3=001, Funct7=0110000: with SHIFT_ROTATE_EN → Rotate=1, Right=0; without → Illegal=1.
- Reset asserted while OutValid=1 and skid full → OutValid=0 and InReady=1 immediately, without waiting for an edge.

Source files
------------

// File: rtl/shift_issue_if.sv
// Handshake/bus bundle between the shift issue stage, its producer and the shifter.
// The slave modport is the issue stage's view; master is the environment's view.
interface shift_issue_if #(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = $clog2(XLEN)
);
    logic                InValid;
    logic                InReady;
    logic [2:0]          Funct3;
    logic [6:0]          Funct7;
    logic                OpImm;
    logic                W64In;
    logic [XLEN-1:0]     SrcA;
    logic [XLEN-1:0]     SrcB;
    logic                Flush;

    logic                OutValid;
    logic                OutReady;
    logic [XLEN-1:0]     A;
    logic [LOG_XLEN-1:0] Amt;
    logic                Right;
    logic                Rotate;
    logic                W64;
    logic                SubArith;
    logic                Illegal;

    modport slave (
        input  InValid, Funct3, Funct7, OpImm, W64In, SrcA, SrcB, Flush, OutReady,
        output InReady, OutValid, A, Amt, Right, Rotate, W64, SubArith, Illegal
    );

    modport master (
        output InValid, Funct3, Funct7, OpImm, W64In, SrcA, SrcB, Flush, OutReady,
        input  InReady, OutValid, A, Amt, Right, Rotate, W64, SubArith, Illegal
    );
endinterface

// File: rtl/shift_issue.sv
// Registered issue stage for the integer shifter: decodes shift/rotate fields into
// shifter controls and buffers entries in a 2-deep skid buffer. Rotates need SHIFT_ROTATE_EN.
module shift_issue #(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = $clog2(XLEN)
) (
    input  logic clk,
    input  logic reset,
    shift_issue_if.slave bus
);

`ifdef SHIFT_ROTATE_EN
    localparam logic ROT_EN = 1'b1;
`else
    localparam logic ROT_EN = 1'b0;
`endif

    localparam logic [6:0] F_BASE = 7'b0000000;
    localparam logic [6:0] F_ARITH = 7'b0100000;
    localparam logic [6:0] F_ROT = 7'b0110000;

    typedef struct packed {
        logic [XLEN-1:0]     a;
        logic [LOG_XLEN-1:0] amt;
        logic                right;
        logic                rotate;
        logic                w64;
        logic                subarith;
        logic                illegal;
    } entry_t;

    entry_t dec;
    entry_t out_q;
    entry_t skid_q;
    logic   ov_q;
    logic   sv_q;
    logic   accept;

    logic [6:0] f;
    logic       legal;
    logic       right;
    logic       rotate;
    logic       subarith;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        f        = bus.Funct7;
        legal    = 1'b0;
        right    = 1'b0;
        rotate   = 1'b0;
        subarith = 1'b0;

        // RV64 immediates carry shamt[5] in Funct7[0]; it is not part of the opcode.
        if (bus.OpImm && XLEN == 64)
            f[0] = 1'b0;

        case (bus.Funct3)
            3'b001: begin
                if (f == F_BASE) begin
                    legal = 1'b1;
                end else if (f == F_ROT && !bus.OpImm && ROT_EN) begin
                    legal  = 1'b1;
                    rotate = 1'b1;
                end
            end
            3'b101: begin
                if (f == F_BASE) begin
                    legal = 1'b1;
                    right = 1'b1;
                end else if (f == F_ARITH) begin
                    legal    = 1'b1;
                    right    = 1'b1;
                    subarith = 1'b1;
                end else if (f == F_ROT && ROT_EN) begin
                    legal  = 1'b1;
                    right  = 1'b1;
                    rotate = 1'b1;
                end
            end
            default: ;
        endcase

        if (bus.W64In && XLEN == 32)
            legal = 1'b0;
        if (bus.W64In && bus.OpImm && bus.Funct7[0])
            legal = 1'b0;
        if (XLEN == 32 && bus.OpImm && bus.Funct7[0])
            legal = 1'b0;

        dec.a        = bus.SrcA;
        dec.amt      = bus.SrcB[LOG_XLEN-1:0];
        dec.right    = legal & right;
        dec.rotate   = legal & rotate;
        dec.w64      = legal & bus.W64In;
        dec.subarith = legal & subarith;
        dec.illegal  = ~legal;
    end

    // Flush blocks acceptance even when the skid is empty.
    assign accept = bus.InValid && !sv_q && !bus.Flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: data registers are reset too, since A/Amt/controls have defined reset values on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q   <= 1'b0;
            sv_q   <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (bus.Flush) begin
            ov_q <= 1'b0;
            sv_q <= 1'b0;
        end else if (!ov_q || bus.OutReady) begin
            if (sv_q) begin
                out_q <= skid_q;
                ov_q  <= 1'b1;
                sv_q  <= 1'b0;
            end else if (accept) begin
                out_q <= dec;
                ov_q  <= 1'b1;
            end else begin
                ov_q <= 1'b0;
            end
        end else if (accept) begin
            // Output is stalled; the newcomer waits behind it in the skid slot.
            skid_q <= dec;
            sv_q   <= 1'b1;
        end
    end

    assign bus.InReady  = ~sv_q;
    assign bus.OutValid = ov_q;
    assign bus.A        = out_q.a;
    assign bus.Amt      = out_q.amt;
    assign bus.Right    = out_q.right;
    assign bus.Rotate   = out_q.rotate;
    assign bus.W64      = out_q.w64;
    assign bus.SubArith = out_q.subarith;
    assign bus.Illegal  = out_q.illegal;

endmodule

// File: tb/tb_shift_issue.sv
// Scoreboard bench for shift_issue (XLEN=64): directed decode vectors, backpressure,
// flush and asynchronous reset. Rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_issue;

    localparam int XLEN = 64;
    localparam int LW   = 6;

`ifdef SHIFT_ROTATE_EN
    localparam logic ROT = 1'b1;
`else
    localparam logic ROT = 1'b0;
`endif

    typedef struct {
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic            opimm;
        logic            w64in;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [LW-1:0]   eamt;
        logic            er, ero, ew, es, eil;
    } vec_t;

    typedef logic [XLEN+LW+4:0] ent_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    ent_t expq[$];
    vec_t vecs[$];

    shift_issue_if #(.XLEN(XLEN)) bus ();

    shift_issue #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [6:0] f7, input logic opimm,
                                input logic w64in, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [LW-1:0] eamt, input logic er, input logic ero,
                                input logic ew, input logic es, input logic eil);
        vec_t v;
        v.f3 = f3; v.f7 = f7; v.opimm = opimm; v.w64in = w64in; v.a = a; v.b = b;
        v.eamt = eamt; v.er = er; v.ero = ero; v.ew = ew; v.es = es; v.eil = eil;
        return v;
    endfunction

    function automatic ent_t expect_of(input vec_t v);
        return {v.a, v.eamt, v.er, v.ero, v.ew, v.es, v.eil};
    endfunction

    function automatic ent_t dut_out();
        return {bus.A, bus.Amt, bus.Right, bus.Rotate, bus.W64, bus.SubArith, bus.Illegal};
    endfunction

    // Monitor: every transfer on the output side is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.OutValid && bus.OutReady) begin
            if (expq.size() == 0) begin
                check("unexpected_output", 128'(dut_out()), 128'(0));
            end else begin
                check("scoreboard", 128'(dut_out()), 128'(expq.pop_front()));
            end
        end
    end

    // Offer one vector; called just after a rising edge, returns just after the accepting edge.
    task automatic send(input vec_t v);
        bit got;
        got = 0;
        bus.Funct3 = v.f3; bus.Funct7 = v.f7; bus.OpImm = v.opimm; bus.W64In = v.w64in;
        bus.SrcA = v.a; bus.SrcB = v.b; bus.InValid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.InReady) begin
                got = 1;
                expq.push_back(expect_of(v));
            end
            @(posedge clk);
            #1;
        end
        bus.InValid = 1'b0;
        if (!got) check("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        bus.InValid = 0; bus.Funct3 = 0; bus.Funct7 = 0; bus.OpImm = 0; bus.W64In = 0;
        bus.SrcA = 0; bus.SrcB = 0; bus.Flush = 0; bus.OutReady = 1;

        //       f3      f7          imm w   a                      b          amt R  Ro   W    S  Il
        vecs.push_back(mk(3'b001, 7'b0000000, 0, 0, 64'h0000_0000_0000_1234, 64'h45, 6'd5,  0, 0,   0,   0, 0));    // SLL
        vecs.push_back(mk(3'b101, 7'b0000000, 0, 0, 64'hFFFF_0000_AAAA_5555, 64'h3F, 6'd63, 1, 0,   0,   0, 0));    // SRL
        vecs.push_back(mk(3'b101, 7'b0100000, 0, 0, 64'h8000_0000_0000_0001, 64'h07, 6'd7,  1, 0,   0,   1, 0));    // SRA
        vecs.push_back(mk(3'b101, 7'b0100001, 1, 0, 64'hDEAD_BEEF_0000_0000, 64'h21, 6'd33, 1, 0,   0,   1, 0));    // SRAI shamt=33
        vecs.push_back(mk(3'b101, 7'b0100001, 1, 1, 64'h1111,               64'h21, 6'd33, 0, 0,   0,   0, 1));    // SRAIW bad shamt
        vecs.push_back(mk(3'b001, 7'b0000000, 0, 1, 64'h2222,               64'h1F, 6'd31, 0, 0,   1,   0, 0));    // SLLW
        vecs.push_back(mk(3'b001, 7'b0110000, 0, 0, 64'h3333,               64'h04, 6'd4,  0, ROT, 0,   0, !ROT)); // ROL
        vecs.push_back(mk(3'b001, 7'b0110000, 1, 0, 64'h4444,               64'h04, 6'd4,  0, 0,   0,   0, 1));    // ROLI illegal
        vecs.push_back(mk(3'b101, 7'b0110000, 1, 0, 64'h5555,               64'h0C, 6'd12, ROT, ROT, 0, 0, !ROT)); // RORI
        vecs.push_back(mk(3'b000, 7'b0000000, 0, 0, 64'h6666,               64'h02, 6'd2,  0, 0,   0,   0, 1));    // bad funct3
        vecs.push_back(mk(3'b101, 7'b0000001, 1, 0, 64'h7777,               64'h25, 6'd37, 1, 0,   0,   0, 0));    // SRLI shamt=37
        vecs.push_back(mk(3'b101, 7'b0000001, 0, 0, 64'h8888,               64'h25, 6'd37, 0, 0,   0,   0, 1));    // SRL bad funct7
        vecs.push_back(mk(3'b101, 7'b0110000, 0, 1, 64'h9999,               64'h3F, 6'd63, ROT, ROT, ROT, 0, !ROT)); // RORW

        reset = 1'b1;
        #12;
        check("reset_outvalid", 128'(bus.OutValid), 128'(0));
        check("reset_inready",  128'(bus.InReady),  128'(1));
        check("reset_outputs",  128'(dut_out()),     128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Streaming at full rate through every decode vector.
        foreach (vecs[i]) send(vecs[i]);
        idle(3);
        check("stream_drained", 128'(expq.size()), 128'(0));

        // Backpressure: op1 held, op2 to skid, op3 waits for InReady.
        bus.OutReady = 1'b0;
        send(mk(3'b001, 7'b0, 0, 0, 64'h1, 64'h01, 6'd1, 0, 0, 0, 0, 0));
        send(mk(3'b001, 7'b0, 0, 0, 64'h2, 64'h02, 6'd2, 0, 0, 0, 0, 0));
        fork
            send(mk(3'b001, 7'b0, 0, 0, 64'h3, 64'h03, 6'd3, 0, 0, 0, 0, 0));
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_inready", 128'(bus.InReady),  128'(0));
                    check("bp_held_a",  128'(bus.A),        128'(64'h1));
                    check("bp_held_v",  128'(bus.OutValid), 128'(1));
                end
                @(posedge clk);
                #1 bus.OutReady = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_release_valid", 128'(bus.OutValid), 128'(1));
                end
            end
        join
        idle(3);
        check("bp_drained", 128'(expq.size()), 128'(0));

        // Flush with both entries full and a new op offered.
        bus.OutReady = 1'b0;
        send(mk(3'b101, 7'b0, 0, 0, 64'hA, 64'h0A, 6'd10, 1, 0, 0, 0, 0));
        send(mk(3'b101, 7'b0, 0, 0, 64'hB, 64'h0B, 6'd11, 1, 0, 0, 0, 0));
        bus.SrcA = 64'hC; bus.SrcB = 64'h0C; bus.InValid = 1'b1; bus.Flush = 1'b1;
        @(posedge clk);
        #1 bus.Flush = 1'b0; bus.InValid = 1'b0;
        expq.delete();
        check("flush_outvalid", 128'(bus.OutValid), 128'(0));
        check("flush_inready",  128'(bus.InReady),  128'(1));
        bus.OutReady = 1'b1;
        idle(4);

        // Asynchronous reset with both entries full, checked between edges.
        bus.OutReady = 1'b0;
        send(mk(3'b001, 7'b0, 0, 0, 64'hD, 64'h0D, 6'd13, 0, 0, 0, 0, 0));
        send(mk(3'b001, 7'b0, 0, 0, 64'hE, 64'h0E, 6'd14, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("pre_reset_full", 128'({bus.OutValid, bus.InReady}), 128'(2'b10));
        #2 reset = 1'b1;
        #1;
        check("async_reset_outvalid", 128'(bus.OutValid), 128'(0));
        check("async_reset_inready",  128'(bus.InReady),  128'(1));
        expq.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.OutReady = 1'b1;
        idle(4);
        check("final_drained", 128'(expq.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
